// File: rtl/jtkunio_pkg.sv
// Shared definitions for the Kunio object-ROM path.
// State encoding of the fetch FSM and the object ROM SDRAM base.
package jtkunio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_W0   = 3'd2,
        ST_W1   = 3'd3,
        ST_FILL = 3'd4
    } objrom_st_t;

    localparam logic [21:0] OBJ_OFFSET = 22'h10_0000;

endpackage

// File: rtl/jtkunio_objrom_tags.sv
// Two-entry tag/data store with combinational lookup,
// registered fill port and a single LRU victim bit.
module jtkunio_objrom_tags #(
    parameter int TW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cs,
    input  logic [TW-1:0] i_tag,
    output logic          o_hit,
    output logic [31:0]   o_data,
    input  logic          i_fill,
    input  logic [TW-1:0] i_fill_tag,
    input  logic [31:0]   i_fill_data
);

    logic [1:0]          r_valid;
    logic [1:0][TW-1:0]  r_tag;
    logic [1:0][31:0]    r_data;
    logic                r_lru;
    logic                w_m0;
    logic                w_m1;

    assign w_m0   = i_cs & r_valid[0] & (r_tag[0] == i_tag);
    assign w_m1   = i_cs & r_valid[1] & (r_tag[1] == i_tag);
    assign o_hit  = w_m0 | w_m1;
    assign o_data = w_m1 ? r_data[1] : r_data[0];

    // A fill always moves the pointer off the entry just written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_tag   <= '0;
            r_data  <= '0;
            r_lru   <= 1'b0;
        end else if (i_fill) begin
            r_valid[r_lru] <= 1'b1;
            r_tag[r_lru]   <= i_fill_tag;
            r_data[r_lru]  <= i_fill_data;
            r_lru          <= ~r_lru;
        end else if (w_m0) begin
            r_lru <= 1'b1;
        end else if (w_m1) begin
            r_lru <= 1'b0;
        end
    end

endmodule

// File: rtl/jtkunio_objrom_resp.sv
// Object-ROM responder: 2-entry cache in front of 2-word SDRAM bursts.
// Bursts always run to completion; hit/miss is re-evaluated back in IDLE.
module jtkunio_objrom_resp
    import jtkunio_pkg::*;
#(
    parameter int             AW     = 18,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic [31:0]    rom_data,
    output logic           rom_ok,
    output logic           sdram_req,
    output logic [SDW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           sdram_dst,
    input  logic [15:0]    sdram_din
);

    objrom_st_t      r_st;
    objrom_st_t      w_st_nx;
    logic            r_req;
    logic [SDW-1:0]  r_sdram_addr;
    logic [AW-2:0]   r_addr_l;
    logic [15:0]     r_word0;
    logic [15:0]     r_word1;
    logic [31:0]     r_last;
    logic            w_hit;
    logic [31:0]     w_hit_data;
    logic            w_fill;
    logic [SDW-1:0]  w_base;
    logic [SDW-1:0]  w_sd_nx;
    logic            w_unused;

    assign w_unused   = rom_addr[0];
    assign w_base     = SDW'({rom_addr[AW-1:1], 1'b0});
    assign w_sd_nx    = OFFSET + w_base;
    assign w_fill     = (r_st == ST_FILL);
    assign rom_ok     = w_hit;
    assign rom_data   = w_hit ? w_hit_data : r_last;
    assign sdram_req  = r_req;
    assign sdram_addr = r_sdram_addr;

    jtkunio_objrom_tags #(
        .TW (AW-1)
    ) u_tags (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cs        (rom_cs),
        .i_tag       (rom_addr[AW-1:1]),
        .o_hit       (w_hit),
        .o_data      (w_hit_data),
        .i_fill      (w_fill),
        .i_fill_tag  (r_addr_l),
        .i_fill_data ({r_word1, r_word0})
    );

    always_comb begin
        w_st_nx = r_st;
        unique case (r_st)
            ST_IDLE: if (rom_cs && !w_hit) w_st_nx = ST_REQ;
            ST_REQ:  if (sdram_ack)        w_st_nx = ST_W0;
            ST_W0:   if (sdram_dst)        w_st_nx = ST_W1;
            ST_W1:   if (sdram_dst)        w_st_nx = ST_FILL;
            ST_FILL:                       w_st_nx = ST_IDLE;
            default:                       w_st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= ST_IDLE;
        else        r_st <= w_st_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= 1'b0;
            r_sdram_addr <= '0;
            r_addr_l     <= '0;
            r_word0      <= '0;
            r_word1      <= '0;
            r_last       <= '0;
        end else begin
            r_last <= rom_data;
            if (r_st == ST_IDLE && w_st_nx == ST_REQ) begin
                r_addr_l     <= rom_addr[AW-1:1];
                r_sdram_addr <= w_sd_nx;
                r_req        <= 1'b1;
            end
            if (r_st == ST_REQ && sdram_ack) r_req <= 1'b0;
            if (r_st == ST_W0 && sdram_dst) r_word0 <= sdram_din;
            if (r_st == ST_W1 && sdram_dst) r_word1 <= sdram_din;
        end
    end

endmodule

// File: tb/tb_jtkunio_objrom_resp.sv
// Bench for jtkunio_objrom_resp: directed scenarios plus
// randomized traffic against a behavioural 2-entry LRU cache model.
module tb_jtkunio_objrom_resp;

    localparam logic [21:0] OFF = 22'h3F_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_dst;
    logic [15:0] sdram_din;

    int total = 0;
    int bad = 0;
    int ack_dly = 1;
    bit rand_gap = 0;

    // reference cache model
    bit          m_valid [2] = '{0, 0};
    logic [16:0] m_tag [2] = '{17'h0, 17'h0};
    bit          m_lru = 0;
    int          m_gen = 0;
    int          m_fills_seen = 0;
    logic [16:0] m_edge_tag = '0;

    // SDRAM responder bookkeeping
    int          resp_fills = 0;
    logic [16:0] resp_tag = '0;
    logic [21:0] resp_addr = '0;

    jtkunio_objrom_resp #(
        .AW     (18),
        .SDW    (22),
        .OFFSET (OFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dst  (sdram_dst),
        .sdram_din  (sdram_din)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [21:0] a);
        if (a == OFF + 22'h000A40) return 16'h1234;
        if (a == OFF + 22'h000A41) return 16'h5678;
        return a[15:0] ^ 16'hA5C3 ^ {a[21:16], 10'h0};
    endfunction

    function automatic logic [21:0] sd_of(input logic [17:0] a);
        logic [21:0] b;
        b = {4'b0, a[17:1], 1'b0};
        return OFF + b;
    endfunction

    function automatic logic [31:0] exp_data(input logic [17:0] a);
        logic [21:0] s;
        s = sd_of(a);
        return {mem(s + 22'd1), mem(s)};
    endfunction

    // Cache model: hits steer LRU away, completed bursts fill the LRU victim
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid[0] = 0;
            m_valid[1] = 0;
            m_lru = 0;
            m_gen++;
            m_fills_seen = resp_fills;
        end else begin
            bit nl;
            nl = m_lru;
            for (int i = 0; i < 2; i++)
                if (rom_cs && m_valid[i] && m_tag[i] == rom_addr[17:1])
                    nl = (i == 0);
            if (resp_fills != m_fills_seen) begin
                m_fills_seen = resp_fills;
                m_valid[m_lru] = 1;
                m_tag[m_lru] = resp_tag;
                nl = !m_lru;
            end
            m_lru = nl;
            m_edge_tag = rom_addr[17:1];
        end
    end

    // SDRAM controller model: ack after a delay, then two data strobes
    initial begin
        sdram_ack = 0;
        sdram_dst = 0;
        sdram_din = '0;
        forever begin
            @(negedge clk);
            if (rst_n && sdram_req) begin
                int g;
                int lat;
                logic [16:0] t;
                t = m_edge_tag;
                g = m_gen;
                resp_addr = OFF + {4'b0, t, 1'b0};
                lat = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (lat) @(negedge clk);
                sdram_ack = 1;
                @(negedge clk);
                sdram_ack = 0;
                for (int w = 0; w < 2; w++) begin
                    if (rand_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
                    sdram_dst = 1;
                    sdram_din = mem(resp_addr + 22'(w));
                    @(negedge clk);
                    sdram_dst = 0;
                end
                if (g == m_gen) begin
                    resp_tag = t;
                    resp_fills++;
                end
            end
        end
    end

    task automatic wait_ok(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            #1;
            if (rom_ok) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        rom_cs = 0;
        rom_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (rom_ok !== 1'b0) begin
            bad++; $display("FAIL reset_ok got=%b want=0", rom_ok);
        end
        total++;
        if (rom_data !== 32'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0", rom_data);
        end
        total++;
        if (sdram_req !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%b want=0", sdram_req);
        end
        total++;
        if (sdram_addr !== 22'h0) begin
            bad++; $display("FAIL reset_addr got=%h want=0", sdram_addr);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cold_miss;
        int n;
        @(negedge clk);
        rom_cs = 1;
        rom_addr = 18'h00A40;
        #1;
        total++;
        if (rom_ok !== 1'b0) begin
            bad++; $display("FAIL cold_ok0 got=%b want=0", rom_ok);
        end
        @(negedge clk);
        #1;
        total++;
        if (sdram_req !== 1'b1 || sdram_addr !== OFF + 22'h000A40) begin
            bad++;
            $display("FAIL cold_req got=%b/%h want=1/%h",
                     sdram_req, sdram_addr, OFF + 22'h000A40);
        end
        wait_ok(30, n);
        total++;
        if (n !== 5) begin
            bad++; $display("FAIL cold_latency got=%0d want=5", n);
        end
        total++;
        if (rom_data !== 32'h5678_1234) begin
            bad++; $display("FAIL cold_data got=%h want=56781234", rom_data);
        end
    endtask

    task automatic test_alternate;
        int n;
        int reqs;
        @(negedge clk);
        rom_addr = 18'h20A40;
        wait_ok(30, n);
        total++;
        if (n < 0 || rom_data !== exp_data(18'h20A40)) begin
            bad++;
            $display("FAIL alt_second got=%h n=%0d want=%h",
                     rom_data, n, exp_data(18'h20A40));
        end
        @(negedge clk);
        rom_addr = 18'h00A40;
        #1;
        total++;
        if (rom_ok !== 1'b1 || rom_data !== 32'h5678_1234) begin
            bad++;
            $display("FAIL alt_hit got=%b/%h want=1/56781234", rom_ok, rom_data);
        end
        reqs = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (sdram_req) reqs++;
        end
        total++;
        if (reqs !== 0) begin
            bad++; $display("FAIL alt_noreq got=%0d want=0", reqs);
        end
    endtask

    task automatic test_addr_change;
        int n;
        @(negedge clk);
        rom_addr = 18'h01000;
        #1;
        total++;
        if (rom_ok !== 1'b0) begin
            bad++; $display("FAIL chg_drop got=%b want=0", rom_ok);
        end
        @(negedge clk);
        #1;
        total++;
        if (sdram_req !== 1'b1 || sdram_addr !== sd_of(18'h01000)) begin
            bad++;
            $display("FAIL chg_req got=%b/%h want=1/%h",
                     sdram_req, sdram_addr, sd_of(18'h01000));
        end
        wait_ok(30, n);
        total++;
        if (n < 0 || rom_data !== exp_data(18'h01000)) begin
            bad++;
            $display("FAIL chg_data got=%h n=%0d want=%h",
                     rom_data, n, exp_data(18'h01000));
        end
    endtask

    task automatic test_mid_burst;
        int  n;
        int  stale;
        int  reqs;
        bit  got;
        bit  prev;
        @(negedge clk);
        rom_addr = 18'h02000;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sdram_ack) begin
                n = i;
                break;
            end
        end
        total++;
        if (n < 0) begin
            bad++; $display("FAIL mid_ack got=none want=ack");
        end
        @(negedge clk);
        rom_addr = 18'h03000;
        stale = 0;
        got = 0;
        reqs = 1;
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (sdram_req && !prev) reqs++;
            prev = sdram_req;
            if (rom_ok && rom_data !== exp_data(18'h03000)) stale++;
            if (rom_ok) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!got || stale != 0) begin
            bad++;
            $display("FAIL mid_new got=%b stale=%0d want=1/0", got, stale);
        end
        total++;
        if (reqs !== 2) begin
            bad++; $display("FAIL mid_reqs got=%0d want=2", reqs);
        end
        @(negedge clk);
        rom_addr = 18'h02000;
        #1;
        total++;
        if (rom_ok !== 1'b1 || rom_data !== exp_data(18'h02000)) begin
            bad++;
            $display("FAIL mid_oldfill got=%b/%h want=1/%h",
                     rom_ok, rom_data, exp_data(18'h02000));
        end
    endtask

    task automatic test_lru;
        int n;
        logic [17:0] seq [3];
        seq = '{18'h04000, 18'h05000, 18'h06000};
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                @(negedge clk);
                rom_addr = seq[0];
                #1;
                total++;
                if (rom_ok !== 1'b1) begin
                    bad++; $display("FAIL lru_hitA got=%b want=1", rom_ok);
                end
            end
            @(negedge clk);
            rom_addr = seq[k];
            wait_ok(30, n);
            total++;
            if (n < 0 || rom_data !== exp_data(seq[k])) begin
                bad++;
                $display("FAIL lru_fill%0d got=%h want=%h", k, rom_data, exp_data(seq[k]));
            end
        end
        @(negedge clk);
        rom_addr = seq[0];
        #1;
        total++;
        if (rom_ok !== 1'b1 || rom_data !== exp_data(seq[0])) begin
            bad++; $display("FAIL lru_keepA got=%b/%h want=1", rom_ok, rom_data);
        end
        @(negedge clk);
        rom_addr = seq[1];
        #1;
        total++;
        if (rom_ok !== 1'b0) begin
            bad++; $display("FAIL lru_evictB got=%b want=0", rom_ok);
        end
        wait_ok(30, n);
    endtask

    task automatic test_wrap;
        int n;
        @(negedge clk);
        rom_addr = 18'h3FFFF;
        @(negedge clk);
        #1;
        total++;
        if (sdram_addr !== 22'h02FFFE) begin
            bad++; $display("FAIL wrap_addr got=%h want=02fffe", sdram_addr);
        end
        wait_ok(30, n);
        total++;
        if (n < 0 || rom_data !== {mem(22'h02FFFF), mem(22'h02FFFE)}) begin
            bad++; $display("FAIL wrap_data got=%h n=%0d", rom_data, n);
        end
        @(negedge clk);
        rom_addr = 18'h3FFFE;
        #1;
        total++;
        if (rom_ok !== 1'b1) begin
            bad++; $display("FAIL wrap_bit0 got=%b want=1", rom_ok);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        rom_addr = 18'h07000;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sdram_ack) begin
                n = i;
                break;
            end
        end
        total++;
        if (n < 0) begin
            bad++; $display("FAIL rmid_ack got=none want=ack");
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if (sdram_req !== 1'b0 || rom_ok !== 1'b0 || rom_data !== 32'h0) begin
            bad++;
            $display("FAIL rmid_rst got=%b/%b/%h want=0/0/0", sdram_req, rom_ok, rom_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        rom_cs = 0;
        repeat (6) @(negedge clk);
        rom_cs = 1;
        rom_addr = 18'h04000;
        #1;
        total++;
        if (rom_ok !== 1'b0) begin
            bad++; $display("FAIL rmid_miss got=%b want=0", rom_ok);
        end
        @(negedge clk);
        #1;
        total++;
        if (sdram_req !== 1'b1) begin
            bad++; $display("FAIL rmid_req got=%b want=1", sdram_req);
        end
        wait_ok(30, n);
        total++;
        if (n < 0 || rom_data !== exp_data(18'h04000)) begin
            bad++; $display("FAIL rmid_data got=%h want=%h", rom_data, exp_data(18'h04000));
        end
    endtask

    task automatic test_random;
        logic [17:0] pool [6];
        logic [31:0] last;
        bit          have_last;
        bit          eh;
        pool = '{18'h00100, 18'h00101, 18'h20100, 18'h10200, 18'h3FFFE, 18'h01234};
        ack_dly = -1;
        rand_gap = 1;
        have_last = 0;
        last = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) rom_addr = pool[$urandom_range(0, 5)];
            rom_cs = ($urandom_range(0, 9) != 0);
            #1;
            eh = rom_cs &&
                 ((m_valid[0] && m_tag[0] == rom_addr[17:1]) ||
                  (m_valid[1] && m_tag[1] == rom_addr[17:1]));
            total++;
            if (rom_ok !== eh) begin
                bad++;
                $display("FAIL rnd_ok c=%0d addr=%h got=%b want=%b", c, rom_addr, rom_ok, eh);
            end
            if (eh) begin
                total++;
                if (rom_data !== exp_data(rom_addr)) begin
                    bad++;
                    $display("FAIL rnd_data c=%0d got=%h want=%h", c, rom_data, exp_data(rom_addr));
                end
                last = exp_data(rom_addr);
                have_last = 1;
            end else if (!rom_cs && have_last) begin
                total++;
                if (rom_data !== last) begin
                    bad++; $display("FAIL rnd_hold c=%0d got=%h want=%h", c, rom_data, last);
                end
            end
            if (sdram_req) begin
                total++;
                if (sdram_addr !== resp_addr) begin
                    bad++;
                    $display("FAIL rnd_addr c=%0d got=%h want=%h", c, sdram_addr, resp_addr);
                end
            end
        end
        rom_cs = 0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        rom_cs = 0;
        rom_addr = '0;
        test_reset;
        test_cold_miss;
        test_alternate;
        test_addr_change;
        test_mid_burst;
        test_lru;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
